// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage: control-bundle bit
// positions (common with the control unit) and WB FSM state encodings.
package writeback_stage_pkg;

    localparam int CTRL_MTR  = 4;  // write back memory data instead of ALU result
    localparam int CTRL_REGW = 6;  // register-file write
    localparam int CTRL_IN   = 7;  // IN instruction: write back in_port
    localparam int CTRL_OUT  = 8;  // OUT instruction: drive out_port

    typedef enum logic {
        WB_RUN     = 1'b0,
        WB_WAIT_IN = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_wb_pipe_reg.sv
// MEM/WB pipeline register. Holds its contents while the stage is stalled;
// a flush on a capturing edge kills the incoming instruction.
module wb_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [CTRL_W-1:0] mem_ctrl,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [ADDR_W-1:0] rd_q,
    output logic [DATA_W-1:0] alu_q,
    output logic [DATA_W-1:0] read_data_q
);

    // Capture the MEM stage on every non-stalled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            read_data_q <= '0;
        end else if (!stall) begin
            wb_valid    <= mem_valid & ~flush;
            ctrl_q      <= mem_ctrl;
            rd_q        <= mem_rd_addr;
            alu_q       <= mem_alu_result;
            read_data_q <= mem_read_data;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, write-back source select, register
// file write port, OUT-port register and the IN-wait FSM with timeout.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int CTRL_W     = 11,
    parameter int IN_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [CTRL_W-1:0] mem_ctrl,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              in_ack,
    output logic              in_timeout,
    output logic              wb_stall,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic              WriteEnable,
    output logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid
);

    localparam int CNT_W = $clog2(IN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_TIMEOUT - 1);

    logic              wb_valid;
    logic [CTRL_W-1:0] ctrl_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] read_data_q;

    wb_state_t         state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              is_in;
    logic              is_out;
    logic              timeout_hit;
    logic              commit;
    logic              unused_ctrl;

    wb_pipe_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CTRL_W (CTRL_W)
    ) u_pipe (
        .clk            (clk),
        .rst            (rst),
        .stall          (wb_stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_ctrl       (mem_ctrl),
        .mem_rd_addr    (mem_rd_addr),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .wb_valid       (wb_valid),
        .ctrl_q         (ctrl_q),
        .rd_q           (rd_q),
        .alu_q          (alu_q),
        .read_data_q    (read_data_q)
    );

    // Only a few control bits matter here; the rest of the bundle is carried along
    assign unused_ctrl = ^ctrl_q;

    assign is_in       = wb_valid & ctrl_q[CTRL_IN];
    assign is_out      = wb_valid & ctrl_q[CTRL_OUT];
    assign timeout_hit = (state == WB_WAIT_IN) && (wait_cnt == CNT_LAST);
    assign wb_stall    = is_in & ~in_valid & ~flush & ~timeout_hit;
    assign commit      = wb_valid & ~wb_stall & ~flush;

    assign WriteAddress = rd_q;
    assign WriteEnable  = commit & ctrl_q[CTRL_REGW];
    assign in_ack       = commit & ctrl_q[CTRL_IN] & in_valid;
    assign in_timeout   = commit & ctrl_q[CTRL_IN] & ~in_valid;

    // Write-back source: IN port beats memory data beats ALU result
    always_comb begin
        WriteData = alu_q;
        if (ctrl_q[CTRL_IN])
            WriteData = in_port;
        else if (ctrl_q[CTRL_MTR])
            WriteData = read_data_q;
    end

    // IN-wait FSM; the counter bounds how long an IN may hold the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WB_RUN;
            wait_cnt <= '0;
        end else if (flush) begin
            state <= WB_RUN;
        end else begin
            case (state)
                WB_RUN: begin
                    if (is_in && !in_valid) begin
                        state    <= WB_WAIT_IN;
                        wait_cnt <= '0;
                    end
                end
                WB_WAIT_IN: begin
                    if (in_valid || timeout_hit)
                        state <= WB_RUN;
                    else if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= WB_RUN;
            endcase
        end
    end

    // OUT-port register with a one-cycle update strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= commit & is_out;
            if (commit && is_out)
                out_port <= alu_q;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver predicts each
// instruction's commit cycle and effect, a negedge monitor checks them.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CTRL_W = 11;
    localparam int T      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic              flush;
    logic [DATA_W-1:0] in_port;
    logic              in_valid;
    logic              in_ack;
    logic              in_timeout;
    logic              wb_stall;
    logic [ADDR_W-1:0] WriteAddress;
    logic              WriteEnable;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;

    always #5 clk = ~clk;

    writeback_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .IN_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
        .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .flush(flush), .in_port(in_port),
        .in_valid(in_valid), .in_ack(in_ack), .in_timeout(in_timeout),
        .wb_stall(wb_stall), .WriteAddress(WriteAddress),
        .WriteEnable(WriteEnable), .WriteData(WriteData),
        .out_port(out_port), .out_valid(out_valid)
    );

    typedef struct {
        int unsigned       cyc;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              ack;
        logic              tmo;
    } ev_t;
    typedef struct { int unsigned cyc; logic [DATA_W-1:0] data; } out_t;
    typedef struct { int unsigned at;  logic [DATA_W-1:0] data; } sch_t;

    ev_t  ev_q[$];
    out_t out_q[$];
    sch_t sched[$];
    ev_t  mon_e;
    out_t mon_o;

    int          checks = 0;
    int          fails  = 0;
    int unsigned cyc    = 0;
    logic [DATA_W-1:0] model_in_port = '0;
    bit last_valid, last_in, last_ev, last_out, rand_flush;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-port event and OUT update must match the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (WriteEnable || in_ack || in_timeout) begin
                if (ev_q.size() == 0) check("unexpected_wb_event", 1, 0);
                else begin
                    mon_e = ev_q.pop_front();
                    check("wb_cycle", cyc, mon_e.cyc);
                    check("write_enable", WriteEnable, mon_e.we);
                    if (mon_e.we) begin
                        check("write_addr", WriteAddress, mon_e.wa);
                        check("write_data", WriteData, mon_e.wd);
                    end
                    check("in_ack", in_ack, mon_e.ack);
                    check("in_timeout", in_timeout, mon_e.tmo);
                end
            end
            if (out_valid) begin
                if (out_q.size() == 0) check("unexpected_out_valid", 1, 0);
                else begin
                    mon_o = out_q.pop_front();
                    check("out_cycle", cyc, mon_o.cyc);
                    check("out_port", out_port, mon_o.data);
                end
            end
        end
    end

    // One clock: apply flush / scheduled IN data, report whether MEM was taken
    task automatic tick(input bit fl, output bit cap);
        flush = fl;
        if (sched.size() > 0 && sched[0].at == cyc) begin
            in_valid = 1'b1;
            in_port  = sched[0].data;
            sched.delete(0);
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        cap = !wb_stall;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Present one MEM-stage slot until WB takes it, then predict its effect.
    // d = cycles of WB residency before in_valid arrives (d > T: never).
    task automatic issue(input bit v, input logic [CTRL_W-1:0] c, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rdata,
                         input int d, input logic [DATA_W-1:0] din, input bit track);
        bit cap, fl;
        int n;
        int unsigned cc;
        ev_t e;
        out_t o;
        n = 0;
        mem_valid = v; mem_ctrl = c; mem_rd_addr = rd;
        mem_alu_result = alu; mem_read_data = rdata;
        do begin
            fl = rand_flush && last_valid && !last_in && ($urandom_range(0, 9) == 0);
            if (fl) begin
                if (last_ev)  ev_q.delete(ev_q.size() - 1);
                if (last_out) out_q.delete(out_q.size() - 1);
            end
            tick(fl, cap);
            n++;
        end while (!cap && n < 40);
        last_valid = 0; last_in = 0; last_ev = 0; last_out = 0;
        if (!cap) begin
            check("capture_bound", 0, 1);
            return;
        end
        if (fl || !v || !track) return;
        last_valid = 1;
        last_in    = c[CTRL_IN];
        e.we = c[CTRL_REGW]; e.wa = rd; e.ack = 0; e.tmo = 0;
        e.wd = c[CTRL_MTR] ? rdata : alu;
        cc = cyc;
        if (c[CTRL_IN]) begin
            if (d <= T) begin
                sched.push_back('{cyc + d, din});
                model_in_port = din;
                e.ack = 1;
                cc = cyc + d;
            end else begin
                e.tmo = 1;
                cc = cyc + T;
            end
            e.wd = model_in_port;
        end
        e.cyc = cc;
        if (c[CTRL_REGW] || c[CTRL_IN]) begin ev_q.push_back(e); last_ev = 1; end
        if (c[CTRL_OUT]) begin
            o.cyc = cc + 1; o.data = alu;
            out_q.push_back(o); last_out = 1;
        end
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) issue(0, '0, '0, '0, '0, 0, '0, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_we"},    WriteEnable, 0);
        check({name, "_wa"},    WriteAddress, 0);
        check({name, "_wd"},    WriteData, 0);
        check({name, "_stall"}, wb_stall, 0);
        check({name, "_ack"},   {in_ack, in_timeout}, 0);
        check({name, "_out"},   {out_valid, out_port}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_valid = 0; mem_ctrl = '0; mem_rd_addr = '0; mem_alu_result = '0;
        mem_read_data = '0; flush = 0; in_port = '0; in_valid = 0; rand_flush = 0;
        mem_valid = 1; mem_ctrl = 11'h0C0; mem_rd_addr = 3'd6; mem_alu_result = 16'h7777;
        @(negedge clk);
        check_all_zero("reset");
        mem_valid = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        // ALU op, load, IN with late data, IN timeout, OUT
        issue(1, 11'h040, 3'd3, 16'h1234, 16'h0000, 0, '0, 1);
        issue(1, 11'h050, 3'd5, 16'h0010, 16'hBEEF, 0, '0, 1);
        issue(1, 11'h0C0, 3'd1, 16'h0000, 16'h0000, 3, 16'h00AA, 1);
        issue(1, 11'h040, 3'd2, 16'h4321, 16'h0000, 0, '0, 1);
        issue(1, 11'h0C0, 3'd4, 16'h0000, 16'h0000, 99, '0, 1);
        issue(1, 11'h100, 3'd7, 16'h5A5A, 16'h0000, 0, '0, 1);
        bubbles(3);
        // Back-to-back INs, each with its own in_valid
        issue(1, 11'h0C0, 3'd1, 16'h0, 16'h0, 0, 16'h1111, 1);
        issue(1, 11'h0C0, 3'd2, 16'h0, 16'h0, 0, 16'h2222, 1);
        issue(1, 11'h0C0, 3'd3, 16'h0, 16'h0, 1, 16'h3333, 1);
        bubbles(6);

        // Flush during WAIT_IN: no write, no ack, stall released
        issue(1, 11'h0C0, 3'd5, 16'h0, 16'h0, 99, '0, 0);
        mem_valid = 0;
        @(negedge clk); check("stall_in_wait", wb_stall, 1);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        check("flush_no_write", {WriteEnable, in_ack, in_timeout}, 0);
        check("flush_stall", wb_stall, 0);
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk); check("after_flush_stall", wb_stall, 0);
        @(posedge clk); #1;

        // Async reset mid-WAIT_IN aborts the IN
        issue(1, 11'h1C0, 3'd6, 16'h0, 16'h0, 99, '0, 0);
        mem_valid = 0;
        @(posedge clk); #3;
        rst = 1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        in_valid = 1; in_port = 16'hDEAD;
        @(negedge clk);
        check("stray_in_valid", {in_ack, WriteEnable, wb_stall}, 0);
        @(posedge clk); #1;
        in_valid = 0; in_port = '0; model_in_port = '0;
        issue(1, 11'h040, 3'd2, 16'hCAFE, 16'h0, 0, '0, 1);
        bubbles(3);

        // Randomized traffic with occasional flushes of non-IN instructions
        rand_flush = 1;
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 9) != 0, CTRL_W'($urandom), ADDR_W'($urandom),
                  DATA_W'($urandom), DATA_W'($urandom), $urandom_range(0, 6),
                  DATA_W'($urandom), 1);
        end
        rand_flush = 0;
        bubbles(12);

        check("events_drained", ev_q.size(), 0);
        check("outs_drained", out_q.size(), 0);
        check("sched_drained", sched.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
